// File: rtl/rf_pkg.sv
// Shared register-file constants, address-width helper and write-port record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

  // Default machine shape shared with decode and writeback.
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  // Address width for a register count; never narrower than one bit.
  function automatic int rf_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int RF_AW = rf_aw(RF_NREGS);

  // One writeback port as seen by the register file in the default shape.
  typedef struct packed {
    logic [RF_AW-1:0]   addr;
    logic [RF_XLEN-1:0] data;
    logic               en;
  } rf_wr_port_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// Write-to-read forwarding for one read port; highest enabled write port wins.
// Latency: combinational, 0 cycles.
// Backpressure: none; always accepts, always produces.
// Ports: rd_addr / stored_data / stored_busy (current array contents at rd_addr),
//        wr_addr / wr_din / we (all write ports, flattened), fwd_data / fwd_busy (result).
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int AW   = RF_AW,
  parameter int NWR  = 1
) (
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     stored_data,
  input  logic                stored_busy,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_din,
  input  logic [NWR-1:0]      we,
  output logic [XLEN-1:0]     fwd_data,
  output logic                fwd_busy
);

  // Ascending scan so a later (higher-index) match overrides an earlier one.
  always_comb begin
    fwd_data = stored_data;
    fwd_busy = stored_busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wr_addr[j*AW +: AW] == rd_addr)) begin
        fwd_data = wr_din[j*XLEN +: XLEN];
        fwd_busy = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multi-port integer register file with per-register busy scoreboard.
// Latency: reads combinational (0 cycles); writes and busy set/clear take effect at the next clk edge.
// Backpressure: none; every enabled write and scoreboard set is accepted each cycle.
// Ports: clk, rst (async active-low); rd_addr -> rd_dout / rd_busy per read port;
//        wr_addr / wr_din / we per write port; sb_set / sb_addr claim a register as busy.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_dout,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_din,
  input  logic [NWR-1:0]      we,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  // Flip-flop storage: async reset and several write ports rule out a RAM macro.
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Writes are applied in ascending port order so the highest port wins on
  // conflicts; the scoreboard set comes last so a new producer beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && !(ZERO_REG && (wr_addr[j*AW +: AW] == '0))) begin
          regs[wr_addr[j*AW +: AW]] <= wr_din[j*XLEN +: XLEN];
          busy[wr_addr[j*AW +: AW]] <= 1'b0;
        end
      end
      if (sb_set && !(ZERO_REG && (sb_addr == '0))) begin
        busy[sb_addr] <= 1'b1;
      end
    end
  end

  // Forwarding is suppressed while reset is held so reads show the cleared
  // state even if writeback is still driving a write.
  logic [NWR-1:0] we_fwd;
  assign we_fwd = rst ? we : '0;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored_data;
    logic [XLEN-1:0] fwd_data;
    logic            stored_busy;
    logic            fwd_busy;
    logic            zero_hit;

    assign addr        = rd_addr[k*AW +: AW];
    assign stored_data = regs[addr];
    assign stored_busy = busy[addr];
    // x0 is forced after forwarding so a write to x0 can never leak through.
    assign zero_hit    = ZERO_REG && (addr == '0);

    if (BYPASS) begin : g_byp
      rf_bypass_mux #(
        .XLEN (XLEN),
        .AW   (AW),
        .NWR  (NWR)
      ) u_bypass_mux (
        .rd_addr     (addr),
        .stored_data (stored_data),
        .stored_busy (stored_busy),
        .wr_addr     (wr_addr),
        .wr_din      (wr_din),
        .we          (we_fwd),
        .fwd_data    (fwd_data),
        .fwd_busy    (fwd_busy)
      );
    end else begin : g_nobyp
      assign fwd_data = stored_data;
      assign fwd_busy = stored_busy;
    end

    assign rd_dout[k*XLEN +: XLEN] = zero_hit ? '0 : fwd_data;
    assign rd_busy[k]              = zero_hit ? 1'b0 : fwd_busy;
  end

endmodule
